// File: rtl/mips_decode_stage.sv
// Registered MIPS-I decode stage with valid/ready handshake, flush and a saturating illegal count.
// Optional MIPS_DECODE_MULDIV_EN adds mult/multu/div/divu/mfhi/mflo decoding.
module mips_decode_stage #(
  parameter int PC_W      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [4:0]           out_rs,
  output logic [4:0]           out_rt,
  output logic [4:0]           out_rd,
  output logic [31:0]          out_imm,
  output logic [3:0]           out_alu_op,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_mem_to_reg,
  output logic                 out_alu_src,
  output logic                 out_branch_ne,
  output logic                 out_branch,
  output logic                 out_jump,
  output logic                 out_jump_reg,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4,  ALU_NOR = 4'd5,  ALU_SLT = 4'd6,  ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8,  ALU_SRL = 4'd9,  ALU_SRA = 4'd10, ALU_LUI = 4'd11;
  localparam logic [3:0] ALU_MUL = 4'd12, ALU_DIV = 4'd13;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch_ne;
    logic            branch;
    logic            jump;
    logic            jump_reg;
    logic            illegal;
  } bundle_t;

  bundle_t              dec, bundle_d, bundle_q;
  logic                 valid_d, valid_q;
  logic [ILL_CNT_W-1:0] ill_cnt_d, ill_cnt_q;
  logic                 accept, rd_is_rt;
  logic [5:0]           op, funct;

  assign op     = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    dec        = '0;
    rd_is_rt   = 1'b0;
    dec.pc     = in_pc;
    dec.rs     = in_instr[25:21];
    dec.rt     = in_instr[20:16];
    dec.imm    = {{16{in_instr[15]}}, in_instr[15:0]};
    dec.alu_op = ALU_ADD;
    case (op)
      6'h00: begin
        dec.rd  = in_instr[15:11];
        dec.imm = '0;
        case (funct)
          6'h20, 6'h21: begin dec.alu_op = ALU_ADD;  dec.reg_write = 1'b1; end
          6'h22, 6'h23: begin dec.alu_op = ALU_SUB;  dec.reg_write = 1'b1; end
          6'h24:        begin dec.alu_op = ALU_AND;  dec.reg_write = 1'b1; end
          6'h25:        begin dec.alu_op = ALU_OR;   dec.reg_write = 1'b1; end
          6'h26:        begin dec.alu_op = ALU_XOR;  dec.reg_write = 1'b1; end
          6'h27:        begin dec.alu_op = ALU_NOR;  dec.reg_write = 1'b1; end
          6'h2A:        begin dec.alu_op = ALU_SLT;  dec.reg_write = 1'b1; end
          6'h2B:        begin dec.alu_op = ALU_SLTU; dec.reg_write = 1'b1; end
          6'h00, 6'h02, 6'h03: begin
            // Shift amount travels on the immediate path.
            dec.alu_op    = (funct == 6'h00) ? ALU_SLL : (funct == 6'h02) ? ALU_SRL : ALU_SRA;
            dec.imm       = {27'b0, in_instr[10:6]};
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
          end
          6'h08:        dec.jump_reg = 1'b1;
`ifdef MIPS_DECODE_MULDIV_EN
          6'h18, 6'h19: dec.alu_op = ALU_MUL;
          6'h1A, 6'h1B: dec.alu_op = ALU_DIV;
          6'h10, 6'h12: begin dec.alu_op = ALU_ADD; dec.reg_write = 1'b1; end
`endif
          default:      dec.illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin dec.alu_op = ALU_ADD;  dec.alu_src = 1'b1; dec.reg_write = 1'b1; rd_is_rt = 1'b1; end
      6'h0A:        begin dec.alu_op = ALU_SLT;  dec.alu_src = 1'b1; dec.reg_write = 1'b1; rd_is_rt = 1'b1; end
      6'h0B:        begin dec.alu_op = ALU_SLTU; dec.alu_src = 1'b1; dec.reg_write = 1'b1; rd_is_rt = 1'b1; end
      6'h0C, 6'h0D, 6'h0E: begin
        dec.alu_op    = (op == 6'h0C) ? ALU_AND : (op == 6'h0D) ? ALU_OR : ALU_XOR;
        dec.imm       = {16'b0, in_instr[15:0]};
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        rd_is_rt      = 1'b1;
      end
      6'h0F: begin
        dec.alu_op    = ALU_LUI;
        dec.imm       = {in_instr[15:0], 16'b0};
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        rd_is_rt      = 1'b1;
      end
      6'h23: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        rd_is_rt       = 1'b1;
      end
      6'h2B: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; rd_is_rt = 1'b1; end
      6'h04: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; rd_is_rt = 1'b1; end
      6'h05: begin dec.branch = 1'b1; dec.branch_ne = 1'b1; dec.alu_op = ALU_SUB; rd_is_rt = 1'b1; end
      6'h02: begin dec.jump = 1'b1; dec.imm = {6'b0, in_instr[25:0]}; end
      6'h03: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = 5'd31;
        dec.imm       = {6'b0, in_instr[25:0]};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (rd_is_rt) dec.rd = in_instr[20:16];
    // An unsupported word must never disturb architectural state downstream.
    if (dec.illegal) begin
      dec.rd         = '0;
      dec.alu_op     = ALU_ADD;
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.alu_src    = 1'b0;
      dec.branch_ne  = 1'b0;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      dec.jump_reg   = 1'b0;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    bundle_d  = bundle_q;
    ill_cnt_d = ill_cnt_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    if (accept) begin
      bundle_d = dec;
      if (dec.illegal && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      bundle_q  <= '0;
      ill_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      bundle_q  <= bundle_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = bundle_q.pc;
  assign out_rs         = bundle_q.rs;
  assign out_rt         = bundle_q.rt;
  assign out_rd         = bundle_q.rd;
  assign out_imm        = bundle_q.imm;
  assign out_alu_op     = bundle_q.alu_op;
  assign out_reg_write  = bundle_q.reg_write;
  assign out_mem_read   = bundle_q.mem_read;
  assign out_mem_write  = bundle_q.mem_write;
  assign out_mem_to_reg = bundle_q.mem_to_reg;
  assign out_alu_src    = bundle_q.alu_src;
  assign out_branch_ne  = bundle_q.branch_ne;
  assign out_branch     = bundle_q.branch;
  assign out_jump       = bundle_q.jump;
  assign out_jump_reg   = bundle_q.jump_reg;
  assign out_illegal    = bundle_q.illegal;
  assign ill_count      = ill_cnt_q;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Directed-vector bench for mips_decode_stage: decode table plus handshake, flush and saturation sequences.
module tb_mips_decode_stage;
  localparam int PC_W = 32;
  localparam int ILL_CNT_W = 8;
  localparam int NV = 20;

  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [4:0] out_rs, out_rt, out_rd;
  logic [3:0] out_alu_op;
  logic out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src;
  logic out_branch_ne, out_branch, out_jump, out_jump_reg, out_illegal;
  logic [ILL_CNT_W-1:0] ill_count;
  logic [9:0] strb;

  int errors = 0, checks = 0;

  // strobe order: rw, mr, mw, m2r, asrc, bne, br, j, jr, ill
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [9:0]  strb;
    logic        full;
  } vec_t;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  assign strb = {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_alu_src,
                 out_branch_ne, out_branch, out_jump, out_jump_reg, out_illegal};

  mips_decode_stage #(.PC_W(PC_W), .ILL_CNT_W(ILL_CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg), .out_alu_src(out_alu_src),
    .out_branch_ne(out_branch_ne), .out_branch(out_branch), .out_jump(out_jump),
    .out_jump_reg(out_jump_reg), .out_illegal(out_illegal), .ill_count(ill_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
    end
  endtask

  initial begin
    int n_ill;
    int exp_cnt;
    logic [ILL_CNT_W-1:0] cnt0;

    vecs[0]  = '{32'h2128FFFC, 5'd9, 5'd8, 5'd8,  32'hFFFFFFFC, 4'd0,  10'h220, 1'b1}; // addi
    vecs[1]  = '{32'h3528F000, 5'd9, 5'd8, 5'd8,  32'h0000F000, 4'd3,  10'h220, 1'b1}; // ori
    vecs[2]  = '{32'h3C081234, 5'd0, 5'd8, 5'd8,  32'h12340000, 4'd11, 10'h220, 1'b1}; // lui
    vecs[3]  = '{32'h0C000010, 5'd0, 5'd0, 5'd31, 32'h00000010, 4'd0,  10'h204, 1'b1}; // jal
    vecs[4]  = '{32'h8D280004, 5'd9, 5'd8, 5'd8,  32'h00000004, 4'd0,  10'h360, 1'b1}; // lw
    vecs[5]  = '{32'hAD280004, 5'd9, 5'd8, 5'd8,  32'h00000004, 4'd0,  10'h0A0, 1'b1}; // sw
    vecs[6]  = '{32'h1128FFFF, 5'd9, 5'd8, 5'd8,  32'hFFFFFFFF, 4'd1,  10'h008, 1'b1}; // beq
    vecs[7]  = '{32'h15280002, 5'd9, 5'd8, 5'd8,  32'h00000002, 4'd1,  10'h018, 1'b1}; // bne
    vecs[8]  = '{32'h01095020, 5'd8, 5'd9, 5'd10, 32'h00000000, 4'd0,  10'h200, 1'b1}; // add
    vecs[9]  = '{32'h000950C3, 5'd0, 5'd9, 5'd10, 32'h00000003, 4'd10, 10'h220, 1'b1}; // sra
    vecs[10] = '{32'h03E00008, 5'd31, 5'd0, 5'd0, 32'h00000000, 4'd0,  10'h002, 1'b1}; // jr
    vecs[11] = '{32'h00000000, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'd8,  10'h220, 1'b1}; // nop
    vecs[12] = '{32'h08000100, 5'd0, 5'd0, 5'd0,  32'h00000100, 4'd0,  10'h004, 1'b1}; // j
    vecs[13] = '{32'h0109502A, 5'd8, 5'd9, 5'd10, 32'h00000000, 4'd6,  10'h200, 1'b1}; // slt
    vecs[14] = '{32'h39288001, 5'd9, 5'd8, 5'd8,  32'h00008001, 4'd4,  10'h220, 1'b1}; // xori
    vecs[15] = '{32'h01095027, 5'd8, 5'd9, 5'd10, 32'h00000000, 4'd5,  10'h200, 1'b1}; // nor
    vecs[16] = '{32'h2D28FFFF, 5'd9, 5'd8, 5'd8,  32'hFFFFFFFF, 4'd7,  10'h220, 1'b1}; // sltiu
`ifdef MIPS_DECODE_MULDIV_EN
    vecs[17] = '{32'h01090018, 5'd8, 5'd9, 5'd0,  32'h00000000, 4'd12, 10'h000, 1'b1}; // mult
`else
    vecs[17] = '{32'h01090018, 5'd8, 5'd9, 5'd0,  32'h00000000, 4'd0,  10'h001, 1'b0}; // mult
`endif
    vecs[18] = '{32'hFC000000, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'd0,  10'h001, 1'b0}; // op 3F
    vecs[19] = '{32'h0000003F, 5'd0, 5'd0, 5'd0,  32'h00000000, 4'd0,  10'h001, 1'b0}; // funct 3F

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset ill_count", 32'(ill_count), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset imm", out_imm, 32'd0);
    chk("reset strobes", 32'(strb), 32'd0);

    // Decode table, streamed back to back
    n_ill = 0;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(4 * i);
      tick();
      if (vecs[i].strb[0]) n_ill++;
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d pc", i), out_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("v%0d strobes", i), 32'(strb), 32'(vecs[i].strb));
      chk($sformatf("v%0d rs", i), 32'(out_rs), 32'(vecs[i].rs));
      chk($sformatf("v%0d rt", i), 32'(out_rt), 32'(vecs[i].rt));
      if (vecs[i].full) begin
        chk($sformatf("v%0d rd", i), 32'(out_rd), 32'(vecs[i].rd));
        chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
        chk($sformatf("v%0d alu_op", i), 32'(out_alu_op), 32'(vecs[i].op));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("drain out_valid", 32'(out_valid), 32'd0);
    chk("table ill_count", 32'(ill_count), 32'(n_ill));

    // Backpressure: bundle held, next instruction waits, then arrives exactly once
    in_valid = 1'b1; in_instr = 32'h2128FFFC; in_pc = 32'h200; out_ready = 1'b0;
    tick();
    chk("bp first valid", 32'(out_valid), 32'd1);
    in_instr = 32'h3528F000; in_pc = 32'h204;
    #1;
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp hold%0d valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d imm", c), out_imm, 32'hFFFFFFFC);
      chk($sformatf("bp hold%0d pc", c), out_pc, 32'h200);
      chk($sformatf("bp hold%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp next valid", 32'(out_valid), 32'd1);
    chk("bp next pc", out_pc, 32'h204);
    chk("bp next imm", out_imm, 32'h0000F000);
    in_valid = 1'b0;
    tick();
    chk("bp no dup", 32'(out_valid), 32'd0);

    // Flush on the accept cycle
    cnt0 = ill_count;
    in_valid = 1'b1; in_instr = 32'h8D280004; flush = 1'b1;
    tick();
    chk("flush lw valid", 32'(out_valid), 32'd0);
    in_instr = 32'hFC000000;
    tick();
    chk("flush ill valid", 32'(out_valid), 32'd0);
    chk("flush ill_count", 32'(ill_count), 32'(cnt0));
    flush = 1'b0;

    // Flush while holding
    in_instr = 32'h2128FFFC; out_ready = 1'b0;
    tick();
    chk("hold valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    chk("flush hold valid", 32'(out_valid), 32'd0);
    flush = 1'b0;

    // Saturation of the illegal counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat reset count", 32'(ill_count), 32'd0);
    in_valid = 1'b1; in_instr = 32'hFC000000; out_ready = 1'b1;
    for (int i = 0; i < (1 << ILL_CNT_W) + 2; i++) begin
      tick();
      exp_cnt = (i + 1 > (1 << ILL_CNT_W) - 1) ? (1 << ILL_CNT_W) - 1 : i + 1;
      chk($sformatf("sat%0d illegal", i), 32'(strb), 32'h001);
      chk($sformatf("sat%0d count", i), 32'(ill_count), 32'(exp_cnt));
    end

    // Reset mid-stream
    rst = 1'b1;
    tick();
    chk("midrst valid", 32'(out_valid), 32'd0);
    chk("midrst count", 32'(ill_count), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
